// File: rtl/iob_fifo_sync_asym_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iob_fifo_sync_asym_pkg
// Description : Shared constant helpers for the asymmetric synchronous FIFO.
//               All sizes are counted in "narrow" words, where narrow is
//               min(W_DATA_W, R_DATA_W).
//                 fifo_ratio     - R, wide/narrow width ratio (power of two)
//                 fifo_incr      - W_INCR / R_INCR, narrow words per port word
//                 fifo_minaddr_w - MINADDR_W, address width in wide words
// Revision    : 1.0 - initial release
// ============================================================================
package iob_fifo_sync_asym_pkg;

    function automatic int fifo_min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int fifo_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // R: number of narrow words packed in one wide word
    function automatic int fifo_ratio(input int w_data_w, input int r_data_w);
        return fifo_max(w_data_w, r_data_w) / fifo_min(w_data_w, r_data_w);
    endfunction

    // Narrow words moved by one access of a port of width port_w
    function automatic int fifo_incr(input int port_w, input int w_data_w, input int r_data_w);
        return port_w / fifo_min(w_data_w, r_data_w);
    endfunction

    // Address width of the storage when organised as wide words
    function automatic int fifo_minaddr_w(input int addr_w, input int w_data_w, input int r_data_w);
        return addr_w - $clog2(fifo_ratio(w_data_w, r_data_w));
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_ram_2p_asym.sv
`default_nettype none
// ============================================================================
// Module      : iob_ram_2p_asym
// Description : Single-clock two-port RAM with independent write and read
//               widths. Storage is organised as wide words; the narrow port
//               addresses one lane of a row, lane 0 in the LSBs (little-endian
//               packing). Read data is registered (one-cycle latency) and
//               holds until the next read.
// Ports       : clk_i     - clock
//               arst_n_i  - asynchronous active-low reset (read register)
//               rst_i     - synchronous reset (read register)
//               w_en_i    - write strobe
//               w_addr_i  - write address, in narrow words
//               w_data_i  - write data, W_DATA_W bits
//               r_en_i    - read strobe
//               r_addr_i  - read address, in narrow words
//               r_data_o  - registered read data, R_DATA_W bits
// Revision    : 1.0 - initial release
// ============================================================================
module iob_ram_2p_asym
    import iob_fifo_sync_asym_pkg::*;
#(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                rst_i,
    input  logic                w_en_i,
    input  logic [ADDR_W-1:0]   w_addr_i,
    input  logic [W_DATA_W-1:0] w_data_i,
    input  logic                r_en_i,
    input  logic [ADDR_W-1:0]   r_addr_i,
    output logic [R_DATA_W-1:0] r_data_o
);

    localparam int c_narrow_w = fifo_min(W_DATA_W, R_DATA_W);
    localparam int c_wide_w   = fifo_max(W_DATA_W, R_DATA_W);
    localparam int c_minaddr  = fifo_minaddr_w(ADDR_W, W_DATA_W, R_DATA_W);
    localparam int c_lane_lg  = ADDR_W - c_minaddr;
    // Keep vector widths legal when the RAM is a single wide row or R == 1
    localparam int c_row_w    = (c_minaddr > 0) ? c_minaddr : 1;
    localparam int c_lane_w   = (c_lane_lg > 0) ? c_lane_lg : 1;

    logic [c_wide_w-1:0] r_mem [2**c_row_w];
    logic [R_DATA_W-1:0] r_rd_data;
    logic [c_row_w-1:0]  w_wr_row;
    logic [c_row_w-1:0]  w_rd_row;

    assign w_wr_row = c_row_w'(w_addr_i >> c_lane_lg);
    assign w_rd_row = c_row_w'(r_addr_i >> c_lane_lg);
    assign r_data_o = r_rd_data;

    generate
        if (W_DATA_W == c_wide_w) begin : g_wr_wide
            always_ff @(posedge clk_i) begin
                if (w_en_i) begin
                    r_mem[w_wr_row] <= w_data_i;
                end
            end
        end else begin : g_wr_narrow
            logic [c_lane_w-1:0] w_wr_lane;
            assign w_wr_lane = c_lane_w'(w_addr_i);
            always_ff @(posedge clk_i) begin
                if (w_en_i) begin
                    r_mem[w_wr_row][int'(w_wr_lane)*c_narrow_w +: c_narrow_w] <= w_data_i;
                end
            end
        end

        if (R_DATA_W == c_wide_w) begin : g_rd_wide
            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) begin
                    r_rd_data <= '0;
                end else if (rst_i) begin
                    r_rd_data <= '0;
                end else if (r_en_i) begin
                    r_rd_data <= r_mem[w_rd_row];
                end
            end
        end else begin : g_rd_narrow
            logic [c_lane_w-1:0] w_rd_lane;
            assign w_rd_lane = c_lane_w'(r_addr_i);
            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) begin
                    r_rd_data <= '0;
                end else if (rst_i) begin
                    r_rd_data <= '0;
                end else if (r_en_i) begin
                    r_rd_data <= r_mem[w_rd_row][int'(w_rd_lane)*c_narrow_w +: c_narrow_w];
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/iob_fifo_sync_asym.sv
`default_nettype none
// ============================================================================
// Module      : iob_fifo_sync_asym
// Description : Synchronous FIFO with different write and read widths.
//               Occupancy is tracked in narrow words in a single level
//               register from which full/empty/almost flags are derived.
//               FWFT=0: popped word appears one cycle after the read.
//               FWFT=1: words are prefetched into an output register; the
//               level still counts that word until it is popped.
// Ports       : clk_i, arst_n_i, rst_i       - clock, async/sync resets
//               w_en_i, w_data_i, w_full_o   - write side
//               r_en_i, r_data_o, r_empty_o  - read side
//               level_o                      - occupancy, narrow words
//               almost_full_thr_i/_o         - level >= threshold
//               almost_empty_thr_i/_o        - level <= threshold
//               overflow_o, underflow_o      - sticky error flags
//               err_clr_i                    - clears error flags
// Revision    : 1.0 - initial release
// ============================================================================
module iob_fifo_sync_asym
    import iob_fifo_sync_asym_pkg::*;
#(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 4,
    parameter int FWFT     = 0
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                rst_i,
    input  logic                w_en_i,
    input  logic [W_DATA_W-1:0] w_data_i,
    output logic                w_full_o,
    input  logic                r_en_i,
    output logic [R_DATA_W-1:0] r_data_o,
    output logic                r_empty_o,
    output logic [ADDR_W:0]     level_o,
    input  logic [ADDR_W:0]     almost_full_thr_i,
    input  logic [ADDR_W:0]     almost_empty_thr_i,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic                overflow_o,
    output logic                underflow_o,
    input  logic                err_clr_i
);

    localparam int c_w_incr = fifo_incr(W_DATA_W, W_DATA_W, R_DATA_W);
    localparam int c_r_incr = fifo_incr(R_DATA_W, W_DATA_W, R_DATA_W);

    localparam logic [ADDR_W:0]   c_cap        = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0]   c_w_step     = (ADDR_W+1)'(c_w_incr);
    localparam logic [ADDR_W:0]   c_r_step     = (ADDR_W+1)'(c_r_incr);
    // Pointers wrap modulo capacity; an increment equal to the capacity
    // truncates to zero, which is exactly that wrap.
    localparam logic [ADDR_W-1:0] c_w_ptr_step = ADDR_W'(c_w_incr);
    localparam logic [ADDR_W-1:0] c_r_ptr_step = ADDR_W'(c_r_incr);

    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W-1:0]   r_rptr;
    logic [ADDR_W:0]     r_level;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_full;
    logic                w_empty;
    logic                w_wr_acc;   // write accepted this edge
    logic                w_pop;      // word leaves the FIFO (level decrement)
    logic                w_fetch;    // RAM read issued (read pointer advance)
    logic [R_DATA_W-1:0] w_ram_data;

    assign w_full   = r_level > (c_cap - c_w_step);
    assign w_wr_acc = w_en_i & ~w_full;

    generate
        if (FWFT != 0) begin : g_fwft
            logic                r_out_valid;
            logic                r_fetch_pend;
            logic [R_DATA_W-1:0] r_out_data;
            logic [ADDR_W:0]     w_in_flight;
            logic [ADDR_W:0]     w_mem_level;

            // Words already fetched out of the RAM but not yet popped
            assign w_in_flight = (r_out_valid  ? c_r_step : '0)
                               + (r_fetch_pend ? c_r_step : '0);
            assign w_mem_level = r_level - w_in_flight;

            assign w_pop    = r_en_i & r_out_valid;
            // One fetch in flight at a time, and only when the output
            // register will be free to receive it.
            assign w_fetch  = (w_mem_level >= c_r_step) & ~r_fetch_pend
                            & (~r_out_valid | w_pop);
            assign w_empty  = ~r_out_valid;
            assign r_data_o = r_out_data;

            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) begin
                    r_out_valid  <= 1'b0;
                    r_fetch_pend <= 1'b0;
                    r_out_data   <= '0;
                end else if (rst_i) begin
                    r_out_valid  <= 1'b0;
                    r_fetch_pend <= 1'b0;
                    r_out_data   <= '0;
                end else begin
                    r_fetch_pend <= w_fetch;
                    if (r_fetch_pend) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_ram_data;
                    end else if (w_pop) begin
                        r_out_valid <= 1'b0;
                    end
                end
            end
        end else begin : g_std
            assign w_empty  = r_level < c_r_step;
            assign w_pop    = r_en_i & ~w_empty;
            assign w_fetch  = w_pop;
            assign r_data_o = w_ram_data;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (rst_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + c_w_ptr_step;
            end
            if (w_fetch) begin
                r_rptr <= r_rptr + c_r_ptr_step;
            end
            r_level     <= r_level + (w_wr_acc ? c_w_step : '0) - (w_pop ? c_r_step : '0);
            // A new error wins over a coincident clear
            r_overflow  <= (w_en_i & w_full)  | (r_overflow  & ~err_clr_i);
            r_underflow <= (r_en_i & w_empty) | (r_underflow & ~err_clr_i);
        end
    end

    iob_ram_2p_asym #(
        .W_DATA_W (W_DATA_W),
        .R_DATA_W (R_DATA_W),
        .ADDR_W   (ADDR_W)
    ) u_ram (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .rst_i    (rst_i),
        .w_en_i   (w_wr_acc),
        .w_addr_i (r_wptr),
        .w_data_i (w_data_i),
        .r_en_i   (w_fetch),
        .r_addr_i (r_rptr),
        .r_data_o (w_ram_data)
    );

    assign w_full_o       = w_full;
    assign r_empty_o      = w_empty;
    assign level_o        = r_level;
    assign almost_full_o  = r_level >= almost_full_thr_i;
    assign almost_empty_o = r_level <= almost_empty_thr_i;
    assign overflow_o     = r_overflow;
    assign underflow_o    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_iob_fifo_sync_asym.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_fifo_sync_asym
// Description : Directed bench for iob_fifo_sync_asym. Three instances:
//               A = 32->8 standard, B = 8->32 standard, F = 32->8 FWFT.
//               Read data is checked by per-instance monitors against
//               queues of expected words filled by the stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_fifo_sync_asym;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] qf[$];

    // Instance A: 32 -> 8, standard
    logic        a_arst_n, a_rst, a_w_en, a_r_en, a_err_clr;
    logic [31:0] a_w_data;
    logic [7:0]  a_r_data;
    logic        a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [4:0]  a_level;
    logic [4:0]  a_af_thr = 5'd12;
    logic [4:0]  a_ae_thr = 5'd0;

    // Instance B: 8 -> 32, standard
    logic        b_arst_n, b_rst, b_w_en, b_r_en, b_err_clr;
    logic [7:0]  b_w_data;
    logic [31:0] b_r_data;
    logic        b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [4:0]  b_level;
    logic [4:0]  b_af_thr = 5'd16;
    logic [4:0]  b_ae_thr = 5'd3;

    // Instance F: 32 -> 8, FWFT
    logic        f_arst_n, f_rst, f_w_en, f_r_en, f_err_clr;
    logic [31:0] f_w_data;
    logic [7:0]  f_r_data;
    logic        f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [4:0]  f_level;
    logic [4:0]  f_af_thr = 5'd8;
    logic [4:0]  f_ae_thr = 5'd0;

    iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4), .FWFT(0)) u_a (
        .clk_i(clk), .arst_n_i(a_arst_n), .rst_i(a_rst),
        .w_en_i(a_w_en), .w_data_i(a_w_data), .w_full_o(a_full),
        .r_en_i(a_r_en), .r_data_o(a_r_data), .r_empty_o(a_empty),
        .level_o(a_level), .almost_full_thr_i(a_af_thr), .almost_empty_thr_i(a_ae_thr),
        .almost_full_o(a_af), .almost_empty_o(a_ae),
        .overflow_o(a_ovf), .underflow_o(a_udf), .err_clr_i(a_err_clr));

    iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4), .FWFT(0)) u_b (
        .clk_i(clk), .arst_n_i(b_arst_n), .rst_i(b_rst),
        .w_en_i(b_w_en), .w_data_i(b_w_data), .w_full_o(b_full),
        .r_en_i(b_r_en), .r_data_o(b_r_data), .r_empty_o(b_empty),
        .level_o(b_level), .almost_full_thr_i(b_af_thr), .almost_empty_thr_i(b_ae_thr),
        .almost_full_o(b_af), .almost_empty_o(b_ae),
        .overflow_o(b_ovf), .underflow_o(b_udf), .err_clr_i(b_err_clr));

    iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4), .FWFT(1)) u_f (
        .clk_i(clk), .arst_n_i(f_arst_n), .rst_i(f_rst),
        .w_en_i(f_w_en), .w_data_i(f_w_data), .w_full_o(f_full),
        .r_en_i(f_r_en), .r_data_o(f_r_data), .r_empty_o(f_empty),
        .level_o(f_level), .almost_full_thr_i(f_af_thr), .almost_empty_thr_i(f_ae_thr),
        .almost_full_o(f_af), .almost_empty_o(f_ae),
        .overflow_o(f_ovf), .underflow_o(f_udf), .err_clr_i(f_err_clr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop one FWFT word once the output register is valid (bounded wait)
    task automatic f_pop(input logic [7:0] e);
        int waited;
        waited = 0;
        while (f_empty && waited < 8) begin
            tick();
            waited++;
        end
        if (f_empty) begin
            n_vec++;
            n_bad++;
            $display("FAIL f_wait: got r_empty_o=1 after %0d cycles, expected 0", waited);
        end else begin
            qf.push_back({24'd0, e});
            f_r_en = 1'b1;
            tick();
            f_r_en = 1'b0;
        end
    endtask

    // Standard mode: data of a read accepted at edge N is checked at the
    // negedge following edge N.
    initial begin : mon_a
        logic pend;
        logic [31:0] e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                n_vec++;
                if (qa.size() == 0) begin
                    n_bad++;
                    $display("FAIL a_rdata: got 0x%0h, expected no read", a_r_data);
                end else begin
                    e = qa.pop_front();
                    if ({24'd0, a_r_data} !== e) begin
                        n_bad++;
                        $display("FAIL a_rdata: got 0x%0h, expected 0x%0h", a_r_data, e);
                    end
                end
            end
            pend = a_arst_n && !a_rst && a_r_en && !a_empty;
        end
    end

    initial begin : mon_b
        logic pend;
        logic [31:0] e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                n_vec++;
                if (qb.size() == 0) begin
                    n_bad++;
                    $display("FAIL b_rdata: got 0x%0h, expected no read", b_r_data);
                end else begin
                    e = qb.pop_front();
                    if (b_r_data !== e) begin
                        n_bad++;
                        $display("FAIL b_rdata: got 0x%0h, expected 0x%0h", b_r_data, e);
                    end
                end
            end
            pend = b_arst_n && !b_rst && b_r_en && !b_empty;
        end
    end

    // FWFT: the word on r_data_o is the one consumed by a pop at the next edge
    initial begin : mon_f
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (f_arst_n && !f_rst && f_r_en && !f_empty) begin
                n_vec++;
                if (qf.size() == 0) begin
                    n_bad++;
                    $display("FAIL f_rdata: got 0x%0h, expected no read", f_r_data);
                end else begin
                    e = qf.pop_front();
                    if ({24'd0, f_r_data} !== e) begin
                        n_bad++;
                        $display("FAIL f_rdata: got 0x%0h, expected 0x%0h", f_r_data, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "timeout");
    end

    initial begin : stim
        {a_arst_n, a_rst, a_w_en, a_r_en, a_err_clr, a_w_data} = '0;
        {b_arst_n, b_rst, b_w_en, b_r_en, b_err_clr, b_w_data} = '0;
        {f_arst_n, f_rst, f_w_en, f_r_en, f_err_clr, f_w_data} = '0;
        tick();
        tick();
        a_arst_n = 1'b1;
        b_arst_n = 1'b1;
        f_arst_n = 1'b1;
        tick();

        // Reset state
        chk("a_rst_level", 32'(a_level), 32'd0);
        chk("a_rst_empty", 32'(a_empty), 32'd1);
        chk("a_rst_full",  32'(a_full),  32'd0);
        chk("a_rst_ae",    32'(a_ae),    32'd1);
        chk("a_rst_af",    32'(a_af),    32'd0);
        chk("a_rst_rdata", 32'(a_r_data), 32'd0);
        chk("a_rst_err",   32'({a_ovf, a_udf}), 32'd0);
        chk("b_rst_state", 32'({b_level, b_empty, b_full, b_af, b_ae, b_ovf}), 32'b00000_1_0_0_1_0);
        chk("b_rst_rdata", b_r_data, 32'd0);
        chk("f_rst_state", 32'({f_level, f_empty, f_full, f_af, f_ae, f_ovf}), 32'b00000_1_0_0_1_0);
        chk("f_rst_rdata", 32'(f_r_data), 32'd0);

        // A: one wide write, four narrow reads, LSB byte first
        a_w_data = 32'h4433_2211;
        a_w_en = 1'b1;
        tick();
        a_w_en = 1'b0;
        chk("a_lvl_after_wr", 32'(a_level), 32'd4);
        chk("a_empty_after_wr", 32'(a_empty), 32'd0);
        a_r_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            qa.push_back(32'h11 * 32'(i + 1));
            tick();
            chk("a_lvl_rd", 32'(a_level), 32'(3 - i));
        end
        a_r_en = 1'b0;
        chk("a_empty_after_rd", 32'(a_empty), 32'd1);

        // A: fill to full, overflow on 5th write, clear
        a_w_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_w_data = 32'h0302_0100 + 32'(i) * 32'h0404_0404;
            tick();
        end
        chk("a_lvl_full", 32'(a_level), 32'd16);
        chk("a_full", 32'(a_full), 32'd1);
        chk("a_af_full", 32'(a_af), 32'd1);
        a_w_data = 32'hDEAD_BEEF;
        tick();
        a_w_en = 1'b0;
        chk("a_lvl_ovf", 32'(a_level), 32'd16);
        chk("a_ovf_set", 32'(a_ovf), 32'd1);
        a_err_clr = 1'b1;
        tick();
        a_err_clr = 1'b0;
        chk("a_ovf_clr", 32'(a_ovf), 32'd0);

        // A: read+write at full -> write rejected, level 16-1
        a_w_data = 32'hBADB_AD00;
        a_w_en = 1'b1;
        a_r_en = 1'b1;
        qa.push_back(32'h00);
        tick();
        a_w_en = 1'b0;
        chk("a_lvl_full_rw", 32'(a_level), 32'd15);
        chk("a_ovf_full_rw", 32'(a_ovf), 32'd1);
        for (int i = 1; i < 4; i++) begin
            qa.push_back(32'(i));
            tick();
        end
        chk("a_lvl_12", 32'(a_level), 32'd12);
        chk("a_nfull_12", 32'(a_full), 32'd0);
        // read+write at 12 -> both accepted, level 12+4-1
        a_w_data = 32'h1312_1110;
        a_w_en = 1'b1;
        qa.push_back(32'h04);
        tick();
        a_w_en = 1'b0;
        chk("a_lvl_12_rw", 32'(a_level), 32'd15);
        // Drain across the pointer wrap: bytes 0x05..0x13
        for (int i = 5; i < 20; i++) begin
            qa.push_back(32'(i));
            tick();
        end
        a_r_en = 1'b0;
        chk("a_lvl_drained", 32'(a_level), 32'd0);
        chk("a_empty_drained", 32'(a_empty), 32'd1);
        a_err_clr = 1'b1;
        tick();
        a_err_clr = 1'b0;
        chk("a_rdata_hold", 32'(a_r_data), 32'h13);

        // B: narrow writes, wide read
        b_w_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_w_data = 8'h11 * 8'(i + 1);
            tick();
        end
        chk("b_lvl_3", 32'(b_level), 32'd3);
        chk("b_empty_3", 32'(b_empty), 32'd1);
        chk("b_ae_3", 32'(b_ae), 32'd1);
        b_w_data = 8'h44;
        tick();
        b_w_en = 1'b0;
        chk("b_empty_4", 32'(b_empty), 32'd0);
        chk("b_ae_4", 32'(b_ae), 32'd0);
        qb.push_back(32'h4433_2211);
        b_r_en = 1'b1;
        tick();
        b_r_en = 1'b0;
        chk("b_lvl_0", 32'(b_level), 32'd0);
        chk("b_empty_0", 32'(b_empty), 32'd1);

        // B: fill with 0xA0..0xAF, then read+write at full and at 12
        b_w_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_w_data = 8'hA0 + 8'(i);
            tick();
        end
        chk("b_lvl_16", 32'(b_level), 32'd16);
        chk("b_full_16", 32'(b_full), 32'd1);
        chk("b_af_16", 32'(b_af), 32'd1);
        b_w_data = 8'h55;
        b_r_en = 1'b1;
        qb.push_back(32'hA3A2_A1A0);
        tick();
        chk("b_lvl_full_rw", 32'(b_level), 32'd12);
        chk("b_nfull_12", 32'(b_full), 32'd0);
        b_w_data = 8'h66;
        qb.push_back(32'hA7A6_A5A4);
        tick();
        b_w_en = 1'b0;
        chk("b_lvl_12_rw", 32'(b_level), 32'd9);
        qb.push_back(32'hABAA_A9A8);
        qb.push_back(32'hAFAE_ADAC);
        tick();
        tick();
        b_r_en = 1'b0;
        chk("b_lvl_1", 32'(b_level), 32'd1);
        chk("b_empty_1", 32'(b_empty), 32'd1);
        chk("b_ovf", 32'(b_ovf), 32'd1);

        // B: underflow, clear coincident with new error, then clear
        b_r_en = 1'b1;
        tick();
        chk("b_udf_set", 32'(b_udf), 32'd1);
        chk("b_lvl_udf", 32'(b_level), 32'd1);
        b_err_clr = 1'b1;
        tick();
        b_r_en = 1'b0;
        chk("b_udf_clr_coinc", 32'(b_udf), 32'd1);
        tick();
        b_err_clr = 1'b0;
        chk("b_udf_clr", 32'(b_udf), 32'd0);

        // B: synchronous reset beats a simultaneous write
        b_rst = 1'b1;
        b_w_en = 1'b1;
        b_w_data = 8'h77;
        tick();
        b_rst = 1'b0;
        b_w_en = 1'b0;
        chk("b_srst_lvl", 32'(b_level), 32'd0);
        chk("b_srst_empty", 32'(b_empty), 32'd1);
        chk("b_srst_rdata", b_r_data, 32'd0);
        b_w_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_w_data = 8'(i + 1);
            tick();
        end
        b_w_en = 1'b0;
        qb.push_back(32'h0403_0201);
        b_r_en = 1'b1;
        tick();
        b_r_en = 1'b0;
        chk("b_srst_fresh_lvl", 32'(b_level), 32'd0);

        // F: first-word-fall-through latency
        f_w_data = 32'hA5A5_A5A5;
        f_w_en = 1'b1;
        tick();
        f_w_en = 1'b0;
        chk("f_empty_e0", 32'(f_empty), 32'd1);
        chk("f_lvl_e0", 32'(f_level), 32'd4);
        tick();
        chk("f_empty_e1", 32'(f_empty), 32'd1);
        tick();
        chk("f_empty_e2", 32'(f_empty), 32'd0);
        chk("f_rdata_e2", 32'(f_r_data), 32'hA5);
        f_w_data = 32'h0403_0201;
        f_w_en = 1'b1;
        tick();
        f_w_en = 1'b0;
        chk("f_lvl_8", 32'(f_level), 32'd8);
        chk("f_af_8", 32'(f_af), 32'd1);
        f_pop(8'hA5);
        chk("f_lvl_7", 32'(f_level), 32'd7);
        for (int i = 0; i < 3; i++) f_pop(8'hA5);
        for (int i = 1; i <= 4; i++) f_pop(8'(i));
        chk("f_lvl_0", 32'(f_level), 32'd0);
        chk("f_empty_0", 32'(f_empty), 32'd1);
        chk("f_ae_0", 32'(f_ae), 32'd1);
        f_r_en = 1'b1;
        tick();
        f_r_en = 1'b0;
        chk("f_udf", 32'(f_udf), 32'd1);
        chk("f_nfull", 32'(f_full), 32'd0);

        // A: asynchronous reset mid-stream at level 8
        a_w_en = 1'b1;
        a_w_data = 32'hAAAA_AAAA;
        tick();
        a_w_data = 32'hBBBB_BBBB;
        tick();
        a_w_en = 1'b0;
        chk("a_lvl_8", 32'(a_level), 32'd8);
        #2;
        a_arst_n = 1'b0;
        #1;
        chk("a_arst_lvl", 32'(a_level), 32'd0);
        chk("a_arst_empty", 32'(a_empty), 32'd1);
        chk("a_arst_rdata", 32'(a_r_data), 32'd0);
        tick();
        a_arst_n = 1'b1;
        tick();
        a_w_data = 32'h8765_4321;
        a_w_en = 1'b1;
        tick();
        a_w_en = 1'b0;
        a_r_en = 1'b1;
        qa.push_back(32'h21);
        qa.push_back(32'h43);
        qa.push_back(32'h65);
        qa.push_back(32'h87);
        for (int i = 0; i < 4; i++) tick();
        a_r_en = 1'b0;
        chk("a_fresh_lvl", 32'(a_level), 32'd0);
        chk("a_udf_none", 32'(a_udf), 32'd0);

        tick();
        tick();
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        chk("qf_drained", 32'(qf.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
